// File: rtl/mem_responder_if.sv
// Request/response bundle between a requester and mem_responder.
// Latency: none (wires only).
// Backpressure: none here; the requester must watch busy / en_out.
// Signals: en_in, ldr_rom[1:0], rom_addr[15:0], rom_data[15:0] toward the responder;
//          rdata[15:0], en_out, busy, err back to the requester.
interface mem_responder_if;
    logic        en_in;
    logic [1:0]  ldr_rom;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] rdata;
    logic        en_out;
    logic        busy;
    logic        err;

    modport master (
        output en_in, ldr_rom, rom_addr, rom_data,
        input  rdata, en_out, busy, err
    );

    modport slave (
        input  en_in, ldr_rom, rom_addr, rom_data,
        output rdata, en_out, busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port 2^DEPTH_LOG2 x 16 word store that serves one load/store/no-op per request.
// Latency: en_out pulses in the 2nd cycle after the en_in sampling edge; one request per 3 cycles.
// Backpressure: en_in is only sampled in IDLE; requests seen while busy (or in DONE) are dropped.
// Ports: clk, rst (async, active low), bus (mem_responder_if.slave).
// Optional feature: define MEM_RANGE_CHK_EN to flag/suppress accesses with nonzero
// rom_addr[15:DEPTH_LOG2]; without it upper address bits alias and err stays 0.
module mem_responder #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_STORE = 2'b10;

    logic [1:0]            state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic [1:0]            cmd_q, cmd_d;
    logic [15:0]           addr_q, addr_d;
    logic [15:0]           wdat_q, wdat_d;
    logic [15:0]           rdata_q, rdata_d;
    logic                  en_out_q, en_out_d;
    logic                  err_q, err_d;

    logic [15:0]           mem_q [DEPTH];
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_widx;
    logic [15:0]           mem_wdat;
    logic [DEPTH_LOG2-1:0] idx;
    logic [15:0]           rd_word;
    logic                  oor;

    assign idx     = addr_q[DEPTH_LOG2-1:0];
    assign rd_word = mem_q[idx];

`ifdef MEM_RANGE_CHK_EN
    assign oor = (addr_q >> DEPTH_LOG2) != 16'h0000;
`else
    // Upper address bits are deliberately ignored: addresses alias modulo DEPTH.
    logic addr_hi_unused;
    assign addr_hi_unused = |(addr_q >> DEPTH_LOG2);
    assign oor            = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        rdata_d  = rdata_q;
        en_out_d = 1'b0;
        err_d    = err_q;
        mem_we   = 1'b0;
        mem_widx = idx;
        mem_wdat = wdat_q;

        case (state_q)
            ST_INIT: begin
                // Zero one word per cycle; this also runs while rst is held low,
                // which is harmless because the sweep restarts from word 0.
                mem_we   = 1'b1;
                mem_widx = cnt_q;
                mem_wdat = 16'h0000;
                if (&cnt_q) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + DEPTH_LOG2'(1);
                end
            end
            ST_IDLE: begin
                if (bus.en_in) begin
                    cmd_d   = bus.ldr_rom;
                    addr_d  = bus.rom_addr;
                    wdat_d  = bus.rom_data;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // en_out is registered here so it is high during DONE.
                en_out_d = 1'b1;
                state_d  = ST_DONE;
                case (cmd_q)
                    CMD_LOAD: begin
                        rdata_d = oor ? 16'hFFFF : rd_word;
                        err_d   = oor;
                    end
                    CMD_STORE: begin
                        mem_we = !oor;
                        err_d  = oor;
                    end
                    default: err_d = 1'b0;
                endcase
            end
            default: state_d = ST_IDLE;    // ST_DONE
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            cmd_q    <= 2'b00;
            addr_q   <= 16'h0000;
            wdat_q   <= 16'h0000;
            rdata_q  <= 16'h0000;
            en_out_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            rdata_q  <= rdata_d;
            en_out_q <= en_out_d;
            err_q    <= err_d;
        end
    end

    // Storage array has no reset; the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdat;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.en_out = en_out_q;
    assign bus.err    = err_q;
    assign bus.busy   = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (DEPTH_LOG2 = 8).
// Latency: expects en_out two edges after the en_in sampling edge.
// Backpressure: drives requests only from IDLE except where dropping is exercised.
module tb_mem_responder;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mem_responder_if bus ();

    mem_responder #(.DEPTH_LOG2(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000 ns");
        $fatal(1);
    end

    // Advance to just after the next rising edge (drive and sample point).
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; lat = edges from sampling edge to en_out, -1 on timeout.
    // Returns one edge after en_out so the DUT is back in IDLE.
    task automatic do_req(input logic [1:0] cmd, input logic [15:0] a,
                          input logic [15:0] d, output int lat);
        int n;
        bus.en_in    = 1'b1;
        bus.ldr_rom  = cmd;
        bus.rom_addr = a;
        bus.rom_data = d;
        tick;
        bus.en_in = 1'b0;
        n = 1;
        while (!bus.en_out && n < 10) begin
            tick;
            n++;
        end
        lat = bus.en_out ? n : -1;
        tick;
    endtask

    task automatic test_reset;
        int n;
        int pulses;
        repeat (3) tick;
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.en_out !== 1'b0) begin n_err++; $display("FAIL rst_en_out: got %b want 0", bus.en_out); end
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus.err); end
        n_cmp++; if (bus.rdata !== 16'h0000) begin n_err++; $display("FAIL rst_rdata: got %h want 0000", bus.rdata); end
        // A store offered throughout INIT must be ignored.
        bus.en_in    = 1'b1;
        bus.ldr_rom  = 2'b10;
        bus.rom_addr = 16'h0037;
        bus.rom_data = 16'hDEAD;
        rst = 1'b1;
        n = 0;
        pulses = 0;
        while (bus.busy && n < 1000) begin
            tick;
            n++;
            if (bus.en_out) pulses++;
        end
        bus.en_in = 1'b0;
        n_cmp++; if (n !== 256) begin n_err++; $display("FAIL init_busy_cycles: got %0d want 256", n); end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL init_en_out: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_load_init;
        int lat;
        do_req(2'b01, 16'h0037, 16'h0000, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL load_init_lat: got %0d want 2", lat); end
        n_cmp++; if (bus.rdata !== 16'h0000) begin n_err++; $display("FAIL load_init_rdata: got %h want 0000", bus.rdata); end
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL load_init_err: got %b want 0", bus.err); end
    endtask

    task automatic test_store_load;
        int lat;
        do_req(2'b10, 16'h0012, 16'hBEEF, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL store_lat: got %0d want 2", lat); end
        n_cmp++; if (bus.rdata !== 16'h0000) begin n_err++; $display("FAIL store_rdata_kept: got %h want 0000", bus.rdata); end
        do_req(2'b01, 16'h0012, 16'h0000, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL load_lat: got %0d want 2", lat); end
        n_cmp++; if (bus.rdata !== 16'hBEEF) begin n_err++; $display("FAIL load_back: got %h want beef", bus.rdata); end
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL load_back_err: got %b want 0", bus.err); end
    endtask

    task automatic test_noop;
        int lat;
        do_req(2'b11, 16'h0012, 16'h5555, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL noop11_lat: got %0d want 2", lat); end
        n_cmp++; if (bus.rdata !== 16'hBEEF) begin n_err++; $display("FAIL noop11_rdata: got %h want beef", bus.rdata); end
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL noop11_err: got %b want 0", bus.err); end
        do_req(2'b00, 16'h0105, 16'h5555, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL noop00_lat: got %0d want 2", lat); end
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL noop00_err: got %b want 0", bus.err); end
        // The no-op store data must not have reached word 0x12.
        do_req(2'b01, 16'h0012, 16'h0000, lat);
        n_cmp++; if (bus.rdata !== 16'hBEEF) begin n_err++; $display("FAIL noop_no_write: got %h want beef", bus.rdata); end
    endtask

    task automatic test_back_to_back;
        int pulses;
        logic [15:0] mask;
        pulses = 0;
        mask   = 16'h0000;
        bus.en_in    = 1'b1;
        bus.ldr_rom  = 2'b01;
        bus.rom_addr = 16'h0012;
        for (int i = 1; i <= 13; i++) begin
            tick;
            if (i == 9) bus.en_in = 1'b0;
            if (bus.en_out) begin
                pulses++;
                mask[i] = 1'b1;
            end
        end
        n_cmp++; if (pulses !== 3) begin n_err++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
        n_cmp++; if (mask !== 16'h0124) begin n_err++; $display("FAIL b2b_spacing: got %h want 0124", mask); end
        n_cmp++; if (bus.rdata !== 16'hBEEF) begin n_err++; $display("FAIL b2b_rdata: got %h want beef", bus.rdata); end
    endtask

    task automatic test_range;
        int lat;
        do_req(2'b10, 16'h0105, 16'h1234, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL range_store_lat: got %0d want 2", lat); end
        n_cmp++; if (bus.rdata !== 16'hBEEF) begin n_err++; $display("FAIL range_store_rdata: got %h want beef", bus.rdata); end
`ifdef MEM_RANGE_CHK_EN
        n_cmp++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL range_store_err: got %b want 1", bus.err); end
        do_req(2'b01, 16'h0005, 16'h0000, lat);
        n_cmp++; if (bus.rdata !== 16'h0000) begin n_err++; $display("FAIL range_alias_load: got %h want 0000", bus.rdata); end
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL range_inrange_err: got %b want 0", bus.err); end
        do_req(2'b01, 16'h0105, 16'h0000, lat);
        n_cmp++; if (bus.rdata !== 16'hFFFF) begin n_err++; $display("FAIL range_oor_load: got %h want ffff", bus.rdata); end
        n_cmp++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL range_oor_load_err: got %b want 1", bus.err); end
        do_req(2'b11, 16'h0000, 16'h0000, lat);
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL range_noop_clear: got %b want 0", bus.err); end
`else
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL range_store_err: got %b want 0", bus.err); end
        do_req(2'b01, 16'h0005, 16'h0000, lat);
        n_cmp++; if (bus.rdata !== 16'h1234) begin n_err++; $display("FAIL range_alias_load: got %h want 1234", bus.rdata); end
        n_cmp++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL range_alias_err: got %b want 0", bus.err); end
        do_req(2'b01, 16'h0105, 16'h0000, lat);
        n_cmp++; if (bus.rdata !== 16'h1234) begin n_err++; $display("FAIL range_hi_load: got %h want 1234", bus.rdata); end
`endif
    endtask

    task automatic test_reset_abort;
        int lat;
        int n;
        int pulses;
        do_req(2'b01, 16'h0012, 16'h0000, lat);
        n_cmp++; if (bus.rdata !== 16'hBEEF) begin n_err++; $display("FAIL abort_pre_rdata: got %h want beef", bus.rdata); end
        bus.en_in    = 1'b1;
        bus.ldr_rom  = 2'b10;
        bus.rom_addr = 16'h0020;
        bus.rom_data = 16'hCAFE;
        tick;                       // request sampled, DUT now in ACCESS
        bus.en_in = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL abort_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.rdata !== 16'h0000) begin n_err++; $display("FAIL abort_rdata_rst: got %h want 0000", bus.rdata); end
        pulses = 0;
        tick;
        if (bus.en_out) pulses++;
        tick;
        if (bus.en_out) pulses++;
        rst = 1'b1;
        n = 0;
        while (bus.busy && n < 1000) begin
            tick;
            n++;
            if (bus.en_out) pulses++;
        end
        n_cmp++; if (n !== 256) begin n_err++; $display("FAIL abort_init_cycles: got %0d want 256", n); end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL abort_en_out: got %0d pulses want 0", pulses); end
        do_req(2'b01, 16'h0020, 16'h0000, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL abort_load_lat: got %0d want 2", lat); end
        n_cmp++; if (bus.rdata !== 16'h0000) begin n_err++; $display("FAIL abort_load_rdata: got %h want 0000", bus.rdata); end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b0;
        bus.en_in    = 1'b0;
        bus.ldr_rom  = 2'b00;
        bus.rom_addr = 16'h0000;
        bus.rom_data = 16'h0000;
        test_reset;
        test_load_init;
        test_store_load;
        test_noop;
        test_back_to_back;
        test_range;
        test_reset_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH_LOG2, default 8, log2 of word count (array is 2^DEPTH_LOG2 x 16 bits).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 en_in  input  1  request strobe, sampled only in IDLE.
REQ-005 ldr_rom  input  2  command: 2'b01 load, 2'b10 store, 2'b00/2'b11 no-op.
REQ-006 rom_addr  input  16  word address.
REQ-007 rom_data  input  16  store data.
REQ-008 rdata  output  16  registered load data.
REQ-009 en_out  output  1  one-cycle completion pulse.
REQ-010 busy  output  1  high in INIT, ACCESS and DONE.
REQ-011 err  output  1  registered out-of-range flag for the last completed request.

Function
REQ-012 FSM states SHALL be INIT, IDLE, ACCESS and DONE.
REQ-013 INIT: write 16'h0000 to every word via an internal counter from 0 to 2^DEPTH_LOG2-1, one word per cycle, then go to IDLE; en_in ignored.
REQ-014 IDLE with en_in=1: capture ldr_rom, rom_addr and rom_data, then go to ACCESS.
REQ-015 ACCESS, load: rdata <= mem[addr index]; store: mem[addr index] <= captured data, rdata unchanged; no-op: no access; then go to DONE.
REQ-016 DONE: en_out=1 for exactly one cycle, then go to IDLE.
REQ-017 Latency: en_out SHALL be high in the 2nd cycle after the en_in sampling edge; maximum throughput is one request per 3 cycles.
REQ-018 en_in asserted outside IDLE (including the DONE cycle) SHALL be dropped with no side effect.
REQ-019 Address index is rom_addr[DEPTH_LOG2-1:0].
REQ-020 A no-op SHALL still produce en_out and SHALL clear err.
REQ-021 A store followed by a load of the same address SHALL return the stored value.

Reset
REQ-022 rst low: state=INIT, init counter=0, rdata=16'h0000, en_out=0, err=0, busy=1.
REQ-023 rst asserted mid-request SHALL abort the request; an in-flight store SHALL NOT complete; INIT restarts from word 0.
REQ-024 After rst release, busy SHALL stay high for exactly 2^DEPTH_LOG2 cycles of INIT.

Configuration
REQ-025 Macro MEM_RANGE_CHK_EN, defined:
- any nonzero rom_addr[15:DEPTH_LOG2] suppresses the store;
- a load returns rdata=16'hFFFF;
- err=1 from the ACCESS edge until the next completed request.
REQ-026 Macro MEM_RANGE_CHK_EN, undefined: upper address bits are ignored (address aliasing modulo 2^DEPTH_LOG2) and err is tied 0.

Verification
REQ-027 Reset, then count busy-high cycles after release -> exactly 256; then load addr 16'h0037 -> rdata=16'h0000, en_out 2 cycles after en_in.
REQ-028 Store 16'hBEEF to 16'h0012, then load 16'h0012 -> rdata=16'hBEEF, err=0; store cycle rdata unchanged.
REQ-029 en_in held high for 9 cycles with a load -> exactly 3 en_out pulses, one every 3 cycles.
REQ-030 Store 16'h1234 to 16'h0105:
- with MEM_RANGE_CHK_EN: err=1, and a load of 16'h0005 returns its prior value;
- without the macro: a load of 16'h0005 returns 16'h1234.
REQ-031 rst pulsed low during ACCESS of a store to 16'h0020 -> after INIT, a load of 16'h0020 returns 16'h0000 and en_out is never asserted for the aborted request.
REQ-032 ldr_rom=2'b11 request -> en_out pulse, rdata unchanged, err=0.
